i2c_target: RTL and testbench
=============================

I2C_TARGET -- requirements
Module: i2c_target

Interface
REQ-001 Parameter DEV_ADDR, default 7'b1110110, is the 7-bit I2C address this target answers to.
REQ-002 clk  input  1  system clock; sole clock domain; SHALL be >= 20x SCL frequency.
REQ-003 rst  input  1  synchronous, active-high reset, sampled on the rising edge of clk.
REQ-004 _scl  input  1  I2C clock from the bus initiator, asynchronous to clk.
REQ-005 _sda  inout  1  I2C data; the target drives only 1'b0 or 1'bz, never 1'b1.
REQ-006 reg_q  output  32  register file contents {reg3, reg2, reg1, reg0}, 8 bits each.
REQ-007 wr_stb  output  1  one-clk pulse when a register is written by the bus.
REQ-008 wr_idx  output  2  index of the register written; valid while wr_stb=1.
REQ-009 addr_hit  output  1  one-clk pulse when an address byte matches DEV_ADDR and is ACKed.
REQ-010 busy  output  1  high from an ACKed address until STOP, repeated START, or NACK-terminated read.

Function
REQ-011 _scl and _sda SHALL each pass through a 2-FF synchronizer; all edge and condition detection SHALL use the synchronized values only.
REQ-012 START SHALL be detected as synchronized SDA falling while SCL is high; STOP as SDA rising while SCL is high.
REQ-013 Data bits SHALL be sampled MSB first on each detected SCL rising edge; the target SHALL change its SDA drive only on a detected SCL falling edge.
REQ-014 The state machine SHALL have the states IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK and WAIT_STOP.
REQ-015 IDLE -> ADDR on START; the bit counter clears to 0.
REQ-016 ADDR: after 8 bits, if byte[7:1]==DEV_ADDR, go to ADDR_ACK; otherwise go to WAIT_STOP with SDA released and no ACK.
REQ-017 ADDR_ACK: drive SDA low from the falling edge after bit 8 until the next falling edge, and pulse addr_hit once.
REQ-018 R/W bit (byte[0]) follows standard I2C: 0 = write, next state WR_DATA; 1 = read, next state RD_DATA with shift register loaded from reg[ptr].
REQ-019 Write: the first data byte after the address SHALL load ptr from byte[1:0] (byte[7:2] ignored) with no wr_stb.
REQ-020 Write: each subsequent byte SHALL be written to reg[ptr], then ptr increments modulo 4 (3 wraps to 0).
REQ-021 Write: reg_q update and the wr_stb/wr_idx pulse SHALL occur together, within 4 clk of the detected 8th SCL rising edge.
REQ-022 Every write byte SHALL be ACKed (WR_ACK, same drive timing as REQ-017).
REQ-023 Read: in RD_DATA, drive SDA low for 0-bits and z for 1-bits, MSB first, each bit set on the preceding SCL falling edge.
REQ-024 Read: after 8 bits, release SDA and sample the initiator's ACK on the next SCL rise.
REQ-025 Read, ACK=0: increment ptr modulo 4, reload the shift register from reg[ptr], and return to RD_DATA.
REQ-026 Read, ACK=1 (NACK): go to WAIT_STOP, clear busy, and keep SDA released.
REQ-027 Repeated START in any state SHALL go to ADDR, release SDA, clear the bit counter, and preserve ptr and registers.
REQ-028 STOP in any state SHALL go to IDLE, release SDA, and clear busy; a partial byte SHALL be discarded with no register write.
REQ-029 WAIT_STOP SHALL ignore all SCL/SDA activity except START and STOP.
REQ-030 If START and STOP are both flagged in one clk, STOP SHALL take priority.

Reset
REQ-031 While rst=1: state=IDLE, SDA released (z), reg0..reg3=8'h00, ptr=0, wr_stb=0, wr_idx=0, addr_hit=0, busy=0, synchronizers set to 1.
REQ-032 Reset asserted mid-transaction SHALL abort immediately; after release, the target SHALL ignore bus activity until the next START.

Verification
REQ-033 Write: START, 0xEC, 0x01, 0xA5, 0x3C, STOP -> four ACKs; addr_hit once; wr_stb twice (wr_idx=1, then 2); reg_q=32'h003CA500.
REQ-034 Read: from REQ-033 state, START, 0xEC, 0x01, repeated START, 0xED, read 2 bytes (ACK, then NACK), STOP -> bytes 0xA5, 0x3C on SDA; busy low after NACK; no wr_stb.
REQ-035 Wrap: START, 0xEC, 0x03, 0x11, 0x22, STOP -> reg3=0x11, reg0=0x22 (wr_idx 3 then 0).
REQ-036 Mismatch: START, 0xEE, 0x01, 0xFF, STOP -> SDA never driven low; no addr_hit, no wr_stb; reg_q unchanged.
REQ-037 Abort: STOP after 5 bits of a data byte -> no register change; next transaction ACKed normally.
REQ-038 Reset: rst=1 for 2 clk during bit 4 of the address byte -> all outputs at reset values; SDA z; the next full transaction succeeds.

Source files
------------

// File: rtl/i2c_target.sv
// I2C target answering at DEV_ADDR with a four-byte register file behind an
// auto-incrementing pointer. SCL/SDA are synchronised to clk; bus timing comes from detected edges.
module i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'b1110110
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        _scl,
  inout  wire         _sda,
  output logic [31:0] reg_q,
  output logic        wr_stb,
  output logic [1:0]  wr_idx,
  output logic        addr_hit,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE, ADDR, ADDR_ACK, WR_DATA, WR_ACK, RD_DATA, RD_ACK, WAIT_STOP
  } state_t;

  state_t          r_state, w_state_nx;
  logic            r_scl_meta, r_scl_sync, r_scl_prev;
  logic            r_sda_meta, r_sda_sync, r_sda_prev;
  logic [1:0]      r_arm;
  logic [3:0]      r_bit_cnt, w_bit_cnt_nx;
  logic [6:0]      r_shift, w_shift_nx;
  logic [7:0]      r_tx, w_tx_nx;
  logic            r_sda_oe, w_sda_oe_nx;
  logic [1:0]      r_ptr, w_ptr_nx;
  logic            r_ptr_pend, w_ptr_pend_nx;
  logic            r_rw, w_rw_nx;
  logic            r_ack_ph, w_ack_ph_nx;
  logic [3:0][7:0] r_regs, w_regs_nx;
  logic            w_wr_stb_nx, w_addr_hit_nx, w_busy_nx;
  logic [1:0]      w_wr_idx_nx;
  logic            w_armed, w_scl_rise, w_scl_fall, w_start, w_stop;
  logic [7:0]      w_rx_byte, w_cur_reg, w_nxt_reg;

  // Synchronisers preset to the idle bus level, plus one history stage for edge detection
  always_ff @(posedge clk) begin
    if (rst) begin
      r_scl_meta <= 1'b1;
      r_scl_sync <= 1'b1;
      r_scl_prev <= 1'b1;
      r_sda_meta <= 1'b1;
      r_sda_sync <= 1'b1;
      r_sda_prev <= 1'b1;
      r_arm      <= 2'd0;
    end else begin
      r_scl_meta <= _scl;
      r_scl_sync <= r_scl_meta;
      r_scl_prev <= r_scl_sync;
      r_sda_meta <= _sda;
      r_sda_sync <= r_sda_meta;
      r_sda_prev <= r_sda_sync;
      r_arm      <= (r_arm == 2'd3) ? 2'd3 : r_arm + 2'd1;
    end
  end

  // Detection stays disarmed until the preset pipeline has flushed, so that
  // leaving reset mid-byte cannot fake a START from the stale preset values.
  assign w_armed    = (r_arm == 2'd3);
  assign w_scl_rise = w_armed & r_scl_sync & ~r_scl_prev;
  assign w_scl_fall = w_armed & ~r_scl_sync & r_scl_prev;
  assign w_start    = w_armed & r_scl_sync & r_scl_prev & r_sda_prev & ~r_sda_sync;
  assign w_stop     = w_armed & r_scl_sync & r_scl_prev & ~r_sda_prev & r_sda_sync;
  assign w_rx_byte  = {r_shift, r_sda_sync};
  assign w_cur_reg  = r_regs[r_ptr];
  assign w_nxt_reg  = r_regs[r_ptr + 2'd1];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nx;
    end
  end

  // Next-state and datapath next values
  always_comb begin
    w_state_nx    = r_state;
    w_bit_cnt_nx  = r_bit_cnt;
    w_shift_nx    = r_shift;
    w_tx_nx       = r_tx;
    w_sda_oe_nx   = r_sda_oe;
    w_ptr_nx      = r_ptr;
    w_ptr_pend_nx = r_ptr_pend;
    w_rw_nx       = r_rw;
    w_ack_ph_nx   = r_ack_ph;
    w_regs_nx     = r_regs;
    w_wr_stb_nx   = 1'b0;
    w_wr_idx_nx   = wr_idx;
    w_addr_hit_nx = 1'b0;
    w_busy_nx     = busy;
    if (w_stop) begin
      w_state_nx  = IDLE;
      w_sda_oe_nx = 1'b0;
      w_busy_nx   = 1'b0;
    end else if (w_start) begin
      w_state_nx   = ADDR;
      w_sda_oe_nx  = 1'b0;
      w_busy_nx    = 1'b0;
      w_bit_cnt_nx = 4'd0;
      w_ack_ph_nx  = 1'b0;
    end else begin
      case (r_state)
        ADDR: begin
          if (w_scl_rise) begin
            w_shift_nx   = w_rx_byte[6:0];
            w_bit_cnt_nx = r_bit_cnt + 4'd1;
            if (r_bit_cnt != 4'd7) begin
              w_state_nx = ADDR;
            end else if (w_rx_byte[7:1] == DEV_ADDR) begin
              w_state_nx  = ADDR_ACK;
              w_rw_nx     = w_rx_byte[0];
              w_ack_ph_nx = 1'b0;
            end else begin
              w_state_nx = WAIT_STOP;
            end
          end else begin
            w_state_nx = ADDR;
          end
        end
        ADDR_ACK: begin
          if (!w_scl_fall) begin
            w_state_nx = ADDR_ACK;
          end else if (!r_ack_ph) begin
            w_sda_oe_nx   = 1'b1;
            w_ack_ph_nx   = 1'b1;
            w_addr_hit_nx = 1'b1;
            w_busy_nx     = 1'b1;
            w_ptr_pend_nx = 1'b1;
          end else begin
            w_ack_ph_nx  = 1'b0;
            w_bit_cnt_nx = 4'd0;
            if (r_rw) begin
              // The first read bit goes out on this same falling edge.
              w_state_nx  = RD_DATA;
              w_sda_oe_nx = ~w_cur_reg[7];
              w_tx_nx     = {w_cur_reg[6:0], 1'b0};
            end else begin
              w_state_nx  = WR_DATA;
              w_sda_oe_nx = 1'b0;
            end
          end
        end
        WR_DATA: begin
          if (w_scl_rise) begin
            w_shift_nx   = w_rx_byte[6:0];
            w_bit_cnt_nx = r_bit_cnt + 4'd1;
            if (r_bit_cnt != 4'd7) begin
              w_state_nx = WR_DATA;
            end else if (r_ptr_pend) begin
              w_state_nx    = WR_ACK;
              w_ack_ph_nx   = 1'b0;
              w_ptr_nx      = w_rx_byte[1:0];
              w_ptr_pend_nx = 1'b0;
            end else begin
              w_state_nx         = WR_ACK;
              w_ack_ph_nx        = 1'b0;
              w_regs_nx[r_ptr]   = w_rx_byte;
              w_wr_stb_nx        = 1'b1;
              w_wr_idx_nx        = r_ptr;
              w_ptr_nx           = r_ptr + 2'd1;
            end
          end else begin
            w_state_nx = WR_DATA;
          end
        end
        WR_ACK: begin
          if (!w_scl_fall) begin
            w_state_nx = WR_ACK;
          end else if (!r_ack_ph) begin
            w_sda_oe_nx = 1'b1;
            w_ack_ph_nx = 1'b1;
          end else begin
            w_sda_oe_nx  = 1'b0;
            w_ack_ph_nx  = 1'b0;
            w_bit_cnt_nx = 4'd0;
            w_state_nx   = WR_DATA;
          end
        end
        RD_DATA: begin
          if (w_scl_rise) begin
            w_bit_cnt_nx = r_bit_cnt + 4'd1;
          end else if (w_scl_fall && (r_bit_cnt == 4'd8)) begin
            w_sda_oe_nx = 1'b0;
            w_state_nx  = RD_ACK;
          end else if (w_scl_fall) begin
            w_sda_oe_nx = ~r_tx[7];
            w_tx_nx     = {r_tx[6:0], 1'b0};
          end else begin
            w_state_nx = RD_DATA;
          end
        end
        RD_ACK: begin
          if (!w_scl_rise) begin
            w_state_nx = RD_ACK;
          end else if (!r_sda_sync) begin
            // Prefetch the next byte; it is driven from the coming falling edge.
            w_ptr_nx     = r_ptr + 2'd1;
            w_tx_nx      = w_nxt_reg;
            w_bit_cnt_nx = 4'd0;
            w_state_nx   = RD_DATA;
          end else begin
            w_state_nx  = WAIT_STOP;
            w_busy_nx   = 1'b0;
            w_sda_oe_nx = 1'b0;
          end
        end
        IDLE, WAIT_STOP: begin
          w_state_nx = r_state;
        end
        default: begin
          w_state_nx  = IDLE;
          w_sda_oe_nx = 1'b0;
        end
      endcase
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_bit_cnt  <= 4'd0;
      r_shift    <= 7'd0;
      r_tx       <= 8'h00;
      r_sda_oe   <= 1'b0;
      r_ptr      <= 2'd0;
      r_ptr_pend <= 1'b0;
      r_rw       <= 1'b0;
      r_ack_ph   <= 1'b0;
      r_regs     <= 32'h0000_0000;
      wr_stb     <= 1'b0;
      wr_idx     <= 2'd0;
      addr_hit   <= 1'b0;
      busy       <= 1'b0;
    end else begin
      r_bit_cnt  <= w_bit_cnt_nx;
      r_shift    <= w_shift_nx;
      r_tx       <= w_tx_nx;
      r_sda_oe   <= w_sda_oe_nx;
      r_ptr      <= w_ptr_nx;
      r_ptr_pend <= w_ptr_pend_nx;
      r_rw       <= w_rw_nx;
      r_ack_ph   <= w_ack_ph_nx;
      r_regs     <= w_regs_nx;
      wr_stb     <= w_wr_stb_nx;
      wr_idx     <= w_wr_idx_nx;
      addr_hit   <= w_addr_hit_nx;
      busy       <= w_busy_nx;
    end
  end

  assign reg_q = r_regs;
  assign _sda  = r_sda_oe ? 1'b0 : 1'bz;

endmodule

// File: tb/tb_i2c_target.sv
// Scoreboard bench for i2c_target: a bit-banged initiator pushes expected strobes and
// bus responses into queues; a negedge monitor pops and compares them.
module tb_i2c_target;
  localparam int Q = 50;

  typedef struct packed {
    logic [1:0] kind;
    logic [1:0] idx;
    logic [7:0] val;
  } ev_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        scl;
  logic        sda_lo;
  wire         sda_bus;
  logic [31:0] reg_q;
  logic        wr_stb;
  logic [1:0]  wr_idx;
  logic        addr_hit;
  logic        busy;

  int n_tests = 0;
  int n_fail = 0;
  int dut_low_cnt = 0;
  ev_t ev_q[$];
  logic [8:0] bexp_q[$];
  logic [8:0] bobs_q[$];

  assign sda_bus = sda_lo ? 1'b0 : 1'bz;
  pullup (sda_bus);

  always #5 clk = ~clk;

  i2c_target #(.DEV_ADDR(7'b1110110)) dut (
    .clk(clk), .rst(rst), ._scl(scl), ._sda(sda_bus),
    .reg_q(reg_q), .wr_stb(wr_stb), .wr_idx(wr_idx), .addr_hit(addr_hit), .busy(busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic ev_cmp(input ev_t act);
    ev_t e;
    n_tests++;
    if (ev_q.size() == 0) begin
      n_fail++;
      $display("FAIL strobe_unexpected: got %h, required no strobe", act);
    end else begin
      e = ev_q.pop_front();
      if (act !== e) begin
        n_fail++;
        $display("FAIL strobe_event: got %h, required %h", act, e);
      end
    end
  endtask

  task automatic push_hit();
    ev_q.push_back({2'd1, 2'd0, 8'h00});
  endtask

  task automatic push_wr(input logic [1:0] idx, input logic [7:0] val);
    ev_q.push_back({2'd2, idx, val});
  endtask

  // Monitor: counts DUT low-drive and scores strobes and bus observations
  always @(negedge clk) begin
    logic [31:0] sh;
    logic [8:0]  e;
    logic [8:0]  o;
    if (!sda_lo && sda_bus === 1'b0) dut_low_cnt++;
    if (!rst && addr_hit) ev_cmp({2'd1, 2'd0, 8'h00});
    if (!rst && wr_stb) begin
      sh = reg_q >> {wr_idx, 3'b000};
      ev_cmp({2'd2, wr_idx, sh[7:0]});
    end
    while (bobs_q.size() > 0) begin
      o = bobs_q.pop_front();
      n_tests++;
      if (bexp_q.size() == 0) begin
        n_fail++;
        $display("FAIL bus_unexpected: got %h, required nothing", o);
      end else begin
        e = bexp_q.pop_front();
        if (o !== e) begin
          n_fail++;
          $display("FAIL bus_%s: got %h, required %h", e[8] ? "rd_byte" : "ack", o, e);
        end
      end
    end
  end

  task automatic bus_start();
    sda_lo = 1'b0; #Q;
    scl = 1'b1;    #Q;
    sda_lo = 1'b1; #Q;
    scl = 1'b0;    #Q;
  endtask

  task automatic bus_stop();
    sda_lo = 1'b1; #Q;
    scl = 1'b1;    #Q;
    sda_lo = 1'b0; #Q;
  endtask

  task automatic wr_bit(input logic b);
    sda_lo = ~b; #Q;
    scl = 1'b1;  #(2*Q);
    scl = 1'b0;  #Q;
  endtask

  task automatic rd_bit(output logic b);
    sda_lo = 1'b0; #Q;
    scl = 1'b1;    #Q;
    b = sda_bus;   #Q;
    scl = 1'b0;    #Q;
  endtask

  task automatic send_byte(input logic [7:0] d, input logic exp_ack);
    logic a;
    bexp_q.push_back({8'h00, exp_ack});
    for (int i = 7; i >= 0; i--) wr_bit(d[i]);
    rd_bit(a);
    bobs_q.push_back({8'h00, a});
  endtask

  task automatic recv_byte(input logic [7:0] exp_d, input logic ack);
    logic [7:0] d;
    bexp_q.push_back({1'b1, exp_d});
    for (int i = 7; i >= 0; i--) rd_bit(d[i]);
    bobs_q.push_back({1'b1, d});
    wr_bit(ack);
  endtask

  initial begin
    logic a;
    rst = 1'b1;
    scl = 1'b1;
    sda_lo = 1'b0;
    repeat (3) @(negedge clk);
    #2;
    check("rst_reg_q", reg_q, 32'h0000_0000);
    check("rst_wr_stb", 32'(wr_stb), 32'd0);
    check("rst_wr_idx", 32'(wr_idx), 32'd0);
    check("rst_addr_hit", 32'(addr_hit), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sda", 32'(sda_bus), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    #2;

    // Write: pointer 1, then two data bytes
    bus_start();
    push_hit();
    send_byte(8'hEC, 1'b0);
    check("wr_busy_set", 32'(busy), 32'd1);
    send_byte(8'h01, 1'b0);
    push_wr(2'd1, 8'hA5);
    send_byte(8'hA5, 1'b0);
    push_wr(2'd2, 8'h3C);
    send_byte(8'h3C, 1'b0);
    bus_stop();
    #Q;
    check("wr_busy_after_stop", 32'(busy), 32'd0);
    check("wr_reg_q", reg_q, 32'h003C_A500);

    // Read: set pointer, repeated START, read two bytes ACK then NACK
    bus_start();
    push_hit();
    send_byte(8'hEC, 1'b0);
    send_byte(8'h01, 1'b0);
    bus_start();
    check("rd_busy_rstart", 32'(busy), 32'd0);
    push_hit();
    send_byte(8'hED, 1'b0);
    check("rd_busy_set", 32'(busy), 32'd1);
    recv_byte(8'hA5, 1'b0);
    recv_byte(8'h3C, 1'b1);
    check("rd_busy_after_nack", 32'(busy), 32'd0);
    bus_stop();
    #Q;
    check("rd_reg_q", reg_q, 32'h003C_A500);

    // Pointer wrap 3 -> 0
    bus_start();
    push_hit();
    send_byte(8'hEC, 1'b0);
    send_byte(8'h03, 1'b0);
    push_wr(2'd3, 8'h11);
    send_byte(8'h11, 1'b0);
    push_wr(2'd0, 8'h22);
    send_byte(8'h22, 1'b0);
    bus_stop();
    #Q;
    check("wrap_reg_q", reg_q, 32'h113C_A522);

    // Address mismatch: nothing acknowledged, nothing written
    dut_low_cnt = 0;
    bus_start();
    send_byte(8'hEE, 1'b1);
    send_byte(8'h01, 1'b1);
    send_byte(8'hFF, 1'b1);
    bus_stop();
    #Q;
    check("mismatch_sda_low_cycles", 32'(dut_low_cnt), 32'd0);
    check("mismatch_reg_q", reg_q, 32'h113C_A522);

    // Abort: STOP after 5 bits of a data byte, then a normal write
    bus_start();
    push_hit();
    send_byte(8'hEC, 1'b0);
    send_byte(8'h00, 1'b0);
    for (int i = 0; i < 5; i++) wr_bit(1'b1);
    bus_stop();
    #Q;
    check("abort_reg_q", reg_q, 32'h113C_A522);
    check("abort_busy", 32'(busy), 32'd0);
    bus_start();
    push_hit();
    send_byte(8'hEC, 1'b0);
    send_byte(8'h01, 1'b0);
    push_wr(2'd1, 8'h77);
    send_byte(8'h77, 1'b0);
    bus_stop();
    #Q;
    check("after_abort_reg_q", reg_q, 32'h113C_7722);

    // Reset for two clocks during bit 4 of the address byte
    bus_start();
    wr_bit(1'b1);
    wr_bit(1'b1);
    wr_bit(1'b1);
    sda_lo = 1'b1;
    #Q;
    scl = 1'b1;
    #20;
    rst = 1'b1;
    #20;
    rst = 1'b0;
    check("midrst_reg_q", reg_q, 32'h0000_0000);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_wr_stb", 32'(wr_stb), 32'd0);
    check("midrst_wr_idx", 32'(wr_idx), 32'd0);
    check("midrst_addr_hit", 32'(addr_hit), 32'd0);
    #10;
    scl = 1'b0;
    #Q;
    wr_bit(1'b1);
    wr_bit(1'b1);
    wr_bit(1'b0);
    wr_bit(1'b0);
    bexp_q.push_back({8'h00, 1'b1});
    rd_bit(a);
    bobs_q.push_back({8'h00, a});
    bus_stop();
    #Q;
    bus_start();
    push_hit();
    send_byte(8'hEC, 1'b0);
    send_byte(8'h02, 1'b0);
    push_wr(2'd2, 8'h5A);
    send_byte(8'h5A, 1'b0);
    bus_stop();
    #Q;
    check("post_rst_reg_q", reg_q, 32'h005A_0000);

    #(4*Q);
    check("strobes_outstanding", 32'(ev_q.size()), 32'd0);
    check("bus_outstanding", 32'(bexp_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
